// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes and the 4-bit symbol encoding
// used by the scan driver and other display consumers.
package seg7_pkg;

  localparam int unsigned SEG_W       = 7;
  localparam int unsigned NUM_SYMS    = 6;
  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned BCD_NIBBLES = 5;
  localparam int unsigned BCD_W       = 4 * BCD_NIBBLES;

  // Symbol code: 0-9 digit, 10 minus, 11 blank, 12 error
  typedef logic [3:0] sym_t;

  localparam sym_t SYM_MINUS = 4'd10;
  localparam sym_t SYM_BLANK = 4'd11;
  localparam sym_t SYM_ERR   = 4'd12;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_ERR   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // BCD nibble to symbol; non-decimal nibbles render as the error glyph
  function automatic sym_t digit_sym(input logic [3:0] nib);
    return (nib > 4'd9) ? SYM_ERR : sym_t'(nib);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/scroll input bundle and multiplexed display output bundle of seg7_scan_driver.
interface seg7_scan_driver_if;

  logic        load;
  logic [19:0] bcd;
  logic        is_negative;
  logic        scroll_left;
  logic        scroll_right;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic        dp;
  logic [1:0]  window;

  modport master (
    output load, bcd, is_negative, scroll_left, scroll_right,
    input  anode, segments, dp, window
  );

  modport slave (
    input  load, bcd, is_negative, scroll_left, scroll_right,
    output anode, segments, dp, window
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational symbol-code to active-low seven-segment decoder.
module seg7_decoder
  import seg7_pkg::*;
(
  input  sym_t             sym,
  output logic [SEG_W-1:0] segments_c
);

  always_comb begin
    segments_c = SEG_BLANK;
    case (sym)
      4'd0:      segments_c = SEG_0;
      4'd1:      segments_c = SEG_1;
      4'd2:      segments_c = SEG_2;
      4'd3:      segments_c = SEG_3;
      4'd4:      segments_c = SEG_4;
      4'd5:      segments_c = SEG_5;
      4'd6:      segments_c = SEG_6;
      4'd7:      segments_c = SEG_7;
      4'd8:      segments_c = SEG_8;
      4'd9:      segments_c = SEG_9;
      SYM_MINUS: segments_c = SEG_MINUS;
      SYM_ERR:   segments_c = SEG_ERR;
      default:   segments_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver for a signed 5-digit BCD value with a 3-position scroll window.
// Optional macro SEG7_GHOST_BLANK_EN blanks the anodes for BLANK_CYCLES at the start of each slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned PW      = $clog2(REFRESH_DIV);
  localparam int unsigned WIN_MAX = NUM_SYMS - NUM_DIGITS;

  logic [PW-1:0]    presc;
  logic [1:0]       scan;
  logic [1:0]       win;
  sym_t             sym [NUM_SYMS];

  logic [3:0]       anode_q;
  logic [SEG_W-1:0] segments_q;
  logic             dp_q;

  sym_t             load_sym [NUM_SYMS];
  logic [2:0]       msd;
  logic [1:0]       win_nxt;
  logic             term;
  logic             anode_blank;
  logic [3:0]       anode_nxt;
  logic [2:0]       disp_idx;
  sym_t             cur_sym;
  logic [SEG_W-1:0] cur_seg_c;

  // Symbol buffer for an incoming value: leading-zero blanking and minus above the top digit
  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < int'(BCD_NIBBLES); k++) begin
      if (bus.bcd[4*k +: 4] != 4'd0) msd = 3'(k);
    end
    for (int k = 0; k < int'(BCD_NIBBLES); k++) begin
      load_sym[k] = (3'(k) > msd) ? SYM_BLANK : digit_sym(bus.bcd[4*k +: 4]);
    end
    load_sym[NUM_SYMS-1] = SYM_BLANK;
    for (int k = 1; k < int'(NUM_SYMS); k++) begin
      if (bus.is_negative && (3'(k) == msd + 3'd1)) load_sym[k] = SYM_MINUS;
    end
  end

  // Saturating scroll; opposing pulses cancel
  always_comb begin
    win_nxt = win;
    if (bus.scroll_left && !bus.scroll_right && (win != 2'(WIN_MAX))) begin
      win_nxt = win + 2'd1;
    end else if (bus.scroll_right && !bus.scroll_left && (win != 2'd0)) begin
      win_nxt = win - 2'd1;
    end
  end

`ifdef SEG7_GHOST_BLANK_EN
  assign anode_blank = (32'(presc) < BLANK_CYCLES);
`else
  logic unused_blank_cycles;
  assign unused_blank_cycles = |BLANK_CYCLES;
  assign anode_blank         = 1'b0;
`endif

  assign term      = (presc == PW'(REFRESH_DIV - 1));
  assign disp_idx  = 3'(win) + 3'(scan);
  assign cur_sym   = sym[disp_idx];
  assign anode_nxt = anode_blank ? 4'hF : ~(4'b0001 << scan);

  seg7_decoder u_decoder (
    .sym        (cur_sym),
    .segments_c (cur_seg_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      scan       <= 2'd0;
      win        <= 2'd0;
      for (int k = 0; k < int'(NUM_SYMS); k++) sym[k] <= SYM_BLANK;
      anode_q    <= 4'hF;
      segments_q <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      presc <= term ? '0 : presc + PW'(1);
      if (term) scan <= scan + 2'd1;
      win   <= win_nxt;
      if (bus.load) begin
        for (int k = 0; k < int'(NUM_SYMS); k++) sym[k] <= load_sym[k];
      end
      // Outputs share one register stage so anode and segments never disagree
      anode_q    <= anode_nxt;
      segments_q <= cur_seg_c;
      dp_q       <= !((scan == 2'd0) && (win != 2'd0));
    end
  end

  assign bus.anode    = anode_q;
  assign bus.segments = segments_q;
  assign bus.dp       = dp_q;
  assign bus.window   = win;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps plus random loads/scrolls against a display-level model.
module tb_seg7_scan_driver;

  localparam int unsigned RD = 4;
  localparam int unsigned BC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: cycles since reset, window offset, and the glyph each buffer slot shows
  int         t;
  int         mw;
  logic [6:0] msym [6];

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  task automatic model_load(input logic [19:0] b, input logic n);
    int v;
    int d [5];
    int msd;
    v   = int'(b);
    msd = 0;
    for (int k = 0; k < 5; k++) begin
      d[k] = (v >> (4 * k)) & 15;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < 5; k++) msym[k] = (k > msd) ? 7'h7F : digit_seg(d[k]);
    msym[5] = 7'h7F;
    if (n) msym[msd + 1] = 7'h3F;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic cyc(input logic ld, input logic [19:0] b, input logic n,
                     input logic sl, input logic sr, input logic r);
    int         s;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(negedge clk);
    rst              = r;
    bus.load         = ld;
    bus.bcd          = b;
    bus.is_negative  = n;
    bus.scroll_left  = sl;
    bus.scroll_right = sr;
    @(posedge clk);
    if (r) begin
      t  = 0;
      mw = 0;
      for (int k = 0; k < 6; k++) msym[k] = 7'h7F;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      s     = (t / int'(RD)) % 4;
      e_an  = ~(4'(1 << s));
`ifdef SEG7_GHOST_BLANK_EN
      if ((t % int'(RD)) < int'(BC)) e_an = 4'hF;
`endif
      e_seg = msym[mw + s];
      e_dp  = (s == 0 && mw > 0) ? 1'b0 : 1'b1;
      if (sl && !sr)      mw = (mw < 2) ? mw + 1 : 2;
      else if (sr && !sl) mw = (mw > 0) ? mw - 1 : 0;
      if (ld) model_load(b, n);
      t++;
    end
    #1;
    check("anode",    7'(bus.anode),  7'(e_an));
    check("segments", bus.segments,   e_seg);
    check("dp",       7'(bus.dp),     7'(e_dp));
    check("window",   7'(bus.window), 7'(mw));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [19:0] rb;
    bus.load = 1'b0; bus.bcd = '0; bus.is_negative = 1'b0;
    bus.scroll_left = 1'b0; bus.scroll_right = 1'b0;
    t = 0; mw = 0;
    for (int k = 0; k < 6; k++) msym[k] = 7'h7F;

    for (int i = 0; i < 20; i++) cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // -50 at window 0
    cyc(1'b1, 20'h00050, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(17);

    // 16384 scrolled to saturation
    cyc(1'b1, 20'h16384, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    idle(17);

    // Lower saturation, then opposing pulses at window 1
    for (int i = 0; i < 3; i++) cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Error nibble and zero
    cyc(1'b1, 20'h0000A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(17);
    cyc(1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(17);

    // Five significant digits, negative: minus in the top slot
    cyc(1'b1, 20'h98765, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(17);

    // Random loads and scrolls, including load with scroll in the same cycle
    for (int i = 0; i < 400; i++) begin
      rb = 20'($urandom);
      rb = rb >> (4 * $urandom_range(0, 4));
      cyc(($urandom_range(0, 5) == 0), rb, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset mid-slot
    cyc(1'b1, 20'h00123, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
